// File: rtl/haar_mmio_pkg.sv
// Shared types and register map for the Haar window MMIO block: FSM states,
// register offsets below the top of the address space, and CTRL/STATUS bit positions.
package haar_mmio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Register addresses are T - *_OFS, with T = 2**ADDR_W
  localparam int CTRL_OFS   = 4;
  localparam int STATUS_OFS = 3;
  localparam int CYCLES_OFS = 2;
  localparam int RESULT_OFS = 1;

  localparam int CTRL_START  = 0;
  localparam int CTRL_IRQ_EN = 1;

  localparam int STAT_BUSY   = 0;
  localparam int STAT_DONE   = 1;
  localparam int STAT_WR_ERR = 2;

  function automatic logic [15:0] status_word(input state_t s, input logic wr_err);
    logic [15:0] w;
    w = '0;
    w[STAT_BUSY]   = (s == ST_RUN);
    w[STAT_DONE]   = (s == ST_DONE);
    w[STAT_WR_ERR] = wr_err;
    return w;
  endfunction

endpackage

// File: rtl/haar_window_buf.sv
// Integral-image window store: byte-enabled Avalon write port, full-word HW write port that wins
// on address collision, and two registered read ports (1-cycle latency, out-of-range reads give 0).
module haar_window_buf #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 9,
  parameter int BUF_DEPTH = 400
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                avl_re,
  input  logic                avl_we,
  input  logic [ADDR_W-1:0]   avl_addr,
  input  logic [DATA_W/8-1:0] avl_be,
  input  logic [DATA_W-1:0]   avl_wdata,
  output logic [DATA_W-1:0]   avl_rdata,
  input  logic [ADDR_W-1:0]   hw_raddr,
  output logic [DATA_W-1:0]   hw_rdata,
  input  logic                hw_we,
  input  logic [ADDR_W-1:0]   hw_waddr,
  input  logic [DATA_W-1:0]   hw_wdata
);

  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(BUF_DEPTH);

  logic [DATA_W-1:0] mem [BUF_DEPTH];
  logic              hw_ok;
  logic              avl_ok;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < DEPTH;
  endfunction

  assign hw_ok  = hw_we && in_range(hw_waddr);
  // The Avalon write is discarded outright when the classifier writes the same word
  assign avl_ok = avl_we && in_range(avl_addr) && !(hw_ok && (hw_waddr == avl_addr));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
      avl_rdata <= '0;
      hw_rdata  <= '0;
    end else begin
      if (avl_ok) begin
        for (int b = 0; b < DATA_W/8; b++) begin
          if (avl_be[b]) mem[avl_addr][8*b +: 8] <= avl_wdata[8*b +: 8];
        end
      end
      if (hw_ok) mem[hw_waddr] <= hw_wdata;
      avl_rdata <= (avl_re && in_range(avl_addr)) ? mem[avl_addr] : '0;
      hw_rdata  <= in_range(hw_raddr) ? mem[hw_raddr] : '0;
    end
  end

endmodule

// File: rtl/haar_window_mmio.sv
// Avalon-MM slave for the Haar engine: window buffer plus CTRL/STATUS/CYCLES/RESULT, readLatency 1,
// no waitrequest. Optional AVL_IRQ output when HAAR_MMIO_IRQ_EN is defined.
module haar_window_mmio
  import haar_mmio_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 9,
  parameter int BUF_DEPTH = 400,
  parameter int CYC_W     = 24
) (
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic                AVL_CS,
  input  logic                AVL_READ,
  input  logic                AVL_WRITE,
  input  logic [ADDR_W-1:0]   AVL_ADDR,
  input  logic [DATA_W/8-1:0] AVL_BYTE_EN,
  input  logic [DATA_W-1:0]   AVL_WRITEDATA,
  output logic [DATA_W-1:0]   AVL_READDATA,
  input  logic [ADDR_W-1:0]   HW_RADDR,
  output logic [DATA_W-1:0]   HW_RDATA,
  input  logic                HW_WE,
  input  logic [ADDR_W-1:0]   HW_WADDR,
  input  logic [DATA_W-1:0]   HW_WDATA,
  output logic                HW_START,
  input  logic                HW_DONE,
  input  logic                HW_IS_FACE,
`ifdef HAAR_MMIO_IRQ_EN
  output logic                AVL_IRQ,
`endif
  output logic [31:0]         EXPORT_DATA
);

  localparam int              T        = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(T - CTRL_OFS);
  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(T - STATUS_OFS);
  localparam logic [ADDR_W-1:0] A_CYCLES = ADDR_W'(T - CYCLES_OFS);
  localparam logic [ADDR_W-1:0] A_RESULT = ADDR_W'(T - RESULT_OFS);
  localparam logic [ADDR_W:0]   DEPTH    = (ADDR_W+1)'(BUF_DEPTH);

  state_t            state, state_nxt;
  logic              start_acc;
  logic              irq_en, wr_err, is_face;
  logic [CYC_W-1:0]  cycles;
  logic [DATA_W-1:0] reg_rdata, reg_rdata_d, buf_rdata;
  logic              wr, rd, in_buf, busy, ctrl_wr, stat_wr;

  assign wr      = AVL_CS && AVL_WRITE;
  assign rd      = AVL_CS && AVL_READ;
  assign in_buf  = {1'b0, AVL_ADDR} < DEPTH;
  assign busy    = (state == ST_RUN);
  assign ctrl_wr = wr && AVL_BYTE_EN[0] && (AVL_ADDR == A_CTRL);
  assign stat_wr = wr && AVL_BYTE_EN[0] && (AVL_ADDR == A_STATUS);

  haar_window_buf #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BUF_DEPTH(BUF_DEPTH)
  ) u_buf (
    .clk(CLK), .rst_n(RESET_N),
    .avl_re(rd), .avl_we(wr && in_buf && !busy),
    .avl_addr(AVL_ADDR), .avl_be(AVL_BYTE_EN), .avl_wdata(AVL_WRITEDATA),
    .avl_rdata(buf_rdata),
    .hw_raddr(HW_RADDR), .hw_rdata(HW_RDATA),
    .hw_we(HW_WE), .hw_waddr(HW_WADDR), .hw_wdata(HW_WDATA)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start_acc = 1'b0;
    case (state)
      ST_IDLE: if (ctrl_wr && AVL_WRITEDATA[CTRL_START]) begin
        start_acc = 1'b1;
        state_nxt = ST_RUN;
      end
      ST_RUN: if (HW_DONE) state_nxt = ST_DONE;
      ST_DONE: begin
        if (ctrl_wr && AVL_WRITEDATA[CTRL_START]) begin
          start_acc = 1'b1;
          state_nxt = ST_RUN;
        end else if (stat_wr && AVL_WRITEDATA[STAT_DONE]) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    reg_rdata_d = '0;
    if (AVL_ADDR == A_CTRL)   reg_rdata_d[CTRL_IRQ_EN] = irq_en;
    if (AVL_ADDR == A_STATUS) reg_rdata_d[15:0] = status_word(state, wr_err);
    if (AVL_ADDR == A_CYCLES) reg_rdata_d[CYC_W-1:0] = cycles;
    if (AVL_ADDR == A_RESULT) reg_rdata_d[0] = is_face;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      irq_en      <= 1'b0;
      wr_err      <= 1'b0;
      is_face     <= 1'b0;
      cycles      <= '0;
      HW_START    <= 1'b0;
      reg_rdata   <= '0;
      EXPORT_DATA <= '0;
    end else begin
      if (ctrl_wr) irq_en <= AVL_WRITEDATA[CTRL_IRQ_EN];
      if (wr && in_buf && busy)                        wr_err <= 1'b1;
      else if (stat_wr && AVL_WRITEDATA[STAT_WR_ERR])  wr_err <= 1'b0;
      if (busy && HW_DONE) is_face <= HW_IS_FACE;
      // The cycle that sees HW_DONE is the hand-off, not counted as a run cycle
      if (start_acc)                                 cycles <= '0;
      else if (busy && !HW_DONE && (cycles != '1))   cycles <= cycles + 1'b1;
      HW_START    <= start_acc;
      reg_rdata   <= rd ? reg_rdata_d : '0;
      EXPORT_DATA <= {status_word(state, wr_err), 15'd0, is_face};
    end
  end

  // Buffer and register read paths are each zero unless selected
  assign AVL_READDATA = buf_rdata | reg_rdata;

`ifdef HAAR_MMIO_IRQ_EN
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) AVL_IRQ <= 1'b0;
    else AVL_IRQ <= (state_nxt == ST_DONE) && (ctrl_wr ? AVL_WRITEDATA[CTRL_IRQ_EN] : irq_en);
  end
`else
  // IRQ_ENABLE remains a plain software-visible bit in this build
`endif

endmodule

// File: tb/tb_haar_window_mmio.sv
// Directed plus randomized bench for haar_window_mmio against an array/variable reference model.
module tb_haar_window_mmio;

  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 9;
  localparam int BUF_DEPTH = 400;
  localparam int CYC_W     = 24;
  localparam int T         = 1 << ADDR_W;
  localparam logic [8:0] A_CTRL   = 9'(T - 4);
  localparam logic [8:0] A_STATUS = 9'(T - 3);
  localparam logic [8:0] A_CYCLES = 9'(T - 2);
  localparam logic [8:0] A_RESULT = 9'(T - 1);

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        AVL_CS = 1'b0, AVL_READ = 1'b0, AVL_WRITE = 1'b0;
  logic [8:0]  AVL_ADDR = '0;
  logic [3:0]  AVL_BYTE_EN = '0;
  logic [31:0] AVL_WRITEDATA = '0;
  logic [31:0] AVL_READDATA;
  logic [8:0]  HW_RADDR = '0;
  logic [31:0] HW_RDATA;
  logic        HW_WE = 1'b0;
  logic [8:0]  HW_WADDR = '0;
  logic [31:0] HW_WDATA = '0;
  logic        HW_START;
  logic        HW_DONE = 1'b0, HW_IS_FACE = 1'b0;
  logic [31:0] EXPORT_DATA;
`ifdef HAAR_MMIO_IRQ_EN
  logic        AVL_IRQ;
`endif

  always #5 CLK = ~CLK;

  haar_window_mmio #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BUF_DEPTH(BUF_DEPTH), .CYC_W(CYC_W)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .AVL_CS(AVL_CS), .AVL_READ(AVL_READ), .AVL_WRITE(AVL_WRITE),
    .AVL_ADDR(AVL_ADDR), .AVL_BYTE_EN(AVL_BYTE_EN), .AVL_WRITEDATA(AVL_WRITEDATA),
    .AVL_READDATA(AVL_READDATA),
    .HW_RADDR(HW_RADDR), .HW_RDATA(HW_RDATA),
    .HW_WE(HW_WE), .HW_WADDR(HW_WADDR), .HW_WDATA(HW_WDATA),
    .HW_START(HW_START), .HW_DONE(HW_DONE), .HW_IS_FACE(HW_IS_FACE),
`ifdef HAAR_MMIO_IRQ_EN
    .AVL_IRQ(AVL_IRQ),
`endif
    .EXPORT_DATA(EXPORT_DATA)
  );

  logic [31:0] mem_m [BUF_DEPTH];
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mdl_rd(input logic [8:0] a);
    return (int'(a) < BUF_DEPTH) ? mem_m[a] : 32'h0;
  endfunction

  task automatic mdl_wr(input logic [8:0] a, input logic [31:0] d, input logic [3:0] be);
    if (int'(a) < BUF_DEPTH)
      for (int b = 0; b < 4; b++) if (be[b]) mem_m[a][8*b +: 8] = d[8*b +: 8];
  endtask

  // All bus tasks start and end on a falling edge; the rising edge in between samples the inputs
  task automatic avl_wr(input logic [8:0] a, input logic [31:0] d, input logic [3:0] be);
    AVL_CS = 1'b1; AVL_WRITE = 1'b1; AVL_ADDR = a; AVL_WRITEDATA = d; AVL_BYTE_EN = be;
    @(negedge CLK);
    AVL_CS = 1'b0; AVL_WRITE = 1'b0; AVL_BYTE_EN = '0;
  endtask

  task automatic avl_rd(input logic [8:0] a, output logic [31:0] d);
    AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_ADDR = a;
    @(negedge CLK);
    d = AVL_READDATA;
    AVL_CS = 1'b0; AVL_READ = 1'b0;
  endtask

  task automatic hw_wr(input logic [8:0] a, input logic [31:0] d);
    HW_WE = 1'b1; HW_WADDR = a; HW_WDATA = d;
    @(negedge CLK);
    HW_WE = 1'b0;
  endtask

  task automatic hw_done(input logic face);
    HW_DONE = 1'b1; HW_IS_FACE = face;
    @(negedge CLK);
    HW_DONE = 1'b0; HW_IS_FACE = 1'b0;
  endtask

  initial begin
    logic [31:0] rd, old10, d;
    logic [8:0]  a;
    logic [3:0]  be;
    int          starts;

    for (int i = 0; i < BUF_DEPTH; i++) mem_m[i] = '0;

    #12;
    check("reset_readdata", AVL_READDATA, 32'h0);
    check("reset_hw_rdata", HW_RDATA, 32'h0);
    check("reset_export", EXPORT_DATA, 32'h0);
    check("reset_hw_start", {31'd0, HW_START}, 32'h0);
    @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);

    avl_rd(A_RESULT, rd);
    check("result_after_reset", rd, 32'h0);
    @(negedge CLK);
    check("readdata_idle_zero", AVL_READDATA, 32'h0);

    // Byte enables, read issued the cycle right after the write
    avl_wr(9'd5, 32'hAABBCCDD, 4'b1111); mdl_wr(9'd5, 32'hAABBCCDD, 4'b1111);
    avl_wr(9'd5, 32'h11223344, 4'b0101); mdl_wr(9'd5, 32'h11223344, 4'b0101);
    avl_rd(9'd5, rd);
    check("byte_enable", rd, 32'hAA22CC44);

    for (int i = 0; i < 24; i++) begin
      a = 9'($urandom_range(0, BUF_DEPTH + 15));
      d = $urandom;
      be = 4'($urandom_range(0, 15));
      if (i % 3 == 0) begin
        hw_wr(a, d); mdl_wr(a, d, 4'hF);
      end else begin
        avl_wr(a, d, be); mdl_wr(a, d, be);
      end
    end
    for (int i = 0; i < 12; i++) begin
      a = 9'($urandom_range(0, BUF_DEPTH + 3));
      avl_rd(a, rd);
      check("rand_avl_read", rd, mdl_rd(a));
      HW_RADDR = 9'($urandom_range(0, BUF_DEPTH - 1));
      a = HW_RADDR;
      @(negedge CLK);
      check("rand_hw_read", HW_RDATA, mdl_rd(a));
    end

    // Read and write together: old data first, new data next
    AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_WRITE = 1'b1;
    AVL_ADDR = 9'd7; AVL_WRITEDATA = 32'hCAFE0007; AVL_BYTE_EN = 4'hF;
    @(negedge CLK);
    check("rw_same_cycle_old", AVL_READDATA, mdl_rd(9'd7));
    AVL_CS = 1'b0; AVL_READ = 1'b0; AVL_WRITE = 1'b0; AVL_BYTE_EN = '0;
    mdl_wr(9'd7, 32'hCAFE0007, 4'hF);
    avl_rd(9'd7, rd);
    check("rw_same_cycle_new", rd, 32'hCAFE0007);

    avl_wr(9'(BUF_DEPTH), 32'hDEADBEEF, 4'hF);
    avl_wr(9'(T - 5), 32'hDEADBEEF, 4'hF);
    avl_rd(9'(BUF_DEPTH), rd);
    check("write_addr_depth", rd, 32'h0);
    avl_rd(9'(T - 5), rd);
    check("write_addr_gap", rd, 32'h0);

    // Collision: HW word wins, no error flagged
    AVL_CS = 1'b1; AVL_WRITE = 1'b1; AVL_ADDR = 9'd3; AVL_WRITEDATA = 32'h1; AVL_BYTE_EN = 4'hF;
    HW_WE = 1'b1; HW_WADDR = 9'd3; HW_WDATA = 32'h2;
    @(negedge CLK);
    AVL_CS = 1'b0; AVL_WRITE = 1'b0; AVL_BYTE_EN = '0; HW_WE = 1'b0;
    mem_m[3] = 32'h2;
    avl_rd(9'd3, rd);
    check("collision_data", rd, 32'h2);
    avl_rd(A_STATUS, rd);
    check("collision_no_err", rd, 32'h0);

    avl_wr(A_CTRL, 32'h2, 4'hF);
    avl_rd(A_CTRL, rd);
    check("ctrl_irq_en_rb", rd, 32'h2);
    avl_wr(A_CTRL, 32'h0, 4'hF);

    // Full run: 37 RUN cycles with HW_DONE low, then the done pulse
    avl_wr(A_CTRL, 32'h1, 4'hF);
    check("hw_start_pulse", {31'd0, HW_START}, 32'h1);
    starts = 0;
    for (int i = 0; i < 37; i++) begin
      if (HW_START) starts++;
      @(negedge CLK);
    end
    hw_done(1'b1);
    if (HW_START) starts++;
    check("hw_start_count", 32'(starts), 32'd1);
    avl_rd(A_STATUS, rd);
    check("run_status", rd, 32'h2);
    avl_rd(A_CYCLES, rd);
    check("run_cycles", rd, 32'd37);
    avl_rd(A_RESULT, rd);
    check("run_result", rd, 32'h1);
    check("run_export", EXPORT_DATA, 32'h0002_0001);

    // Restart from DONE, then write protection during RUN
    avl_wr(A_CTRL, 32'h1, 4'hF);
    avl_rd(A_STATUS, rd);
    check("restart_status", rd, 32'h1);
    old10 = mdl_rd(9'd10);
    avl_wr(9'd10, ~old10, 4'hF);
    avl_rd(9'd10, rd);
    check("protect_data", rd, old10);
    avl_rd(A_STATUS, rd);
    check("protect_wr_err", rd, 32'h5);
    hw_done(1'b0);
    avl_rd(A_STATUS, rd);
    check("done2_status", rd, 32'h6);
    avl_wr(A_STATUS, 32'h4, 4'h1);
    avl_rd(A_STATUS, rd);
    check("w1c_wr_err", rd, 32'h2);
    avl_wr(A_STATUS, 32'h2, 4'h1);
    avl_rd(A_STATUS, rd);
    check("w1c_done", rd, 32'h0);
    hw_done(1'b1);
    avl_rd(A_RESULT, rd);
    check("done_ignored_idle", rd, 32'h0);

`ifdef HAAR_MMIO_IRQ_EN
    avl_wr(A_CTRL, 32'h3, 4'hF);
    repeat (3) @(negedge CLK);
    hw_done(1'b1);
    check("irq_set", {31'd0, AVL_IRQ}, 32'h1);
    avl_wr(A_STATUS, 32'h2, 4'h1);
    check("irq_clear", {31'd0, AVL_IRQ}, 32'h0);
`endif

    // Reset mid-run abandons everything
    avl_wr(A_CTRL, 32'h1, 4'hF);
    repeat (4) @(negedge CLK);
    RESET_N = 1'b0;
    #1;
    check("rst_run_start", {31'd0, HW_START}, 32'h0);
    check("rst_run_readdata", AVL_READDATA, 32'h0);
    check("rst_run_hw_rdata", HW_RDATA, 32'h0);
    check("rst_run_export", EXPORT_DATA, 32'h0);
    @(negedge CLK);
    RESET_N = 1'b1;
    for (int i = 0; i < BUF_DEPTH; i++) mem_m[i] = '0;
    @(negedge CLK);
    avl_rd(A_STATUS, rd);
    check("rst_run_status", rd, 32'h0);
    avl_rd(9'd5, rd);
    check("rst_run_buffer", rd, mdl_rd(9'd5));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/haar_window_mmio.md
# haar_window_mmio

Parametrised Avalon-MM slave that holds the integral-image window buffer and the control/status registers for the Haar classifier engine. The Nios II side fills the buffer, starts a run, and polls or takes an interrupt on completion. The classifier side reads and writes the buffer through a dedicated hardware port. It supersedes the fixed 512-word register file: it adds registered reads, per-byte enables, a start/done state machine, run-cycle measurement and write protection during a run.

## Interface
- DATA_W, 32, word width; must be a multiple of 8
- ADDR_W, 9, Avalon word-address width
- BUF_DEPTH, 400, integral-buffer words; must satisfy BUF_DEPTH <= 2**ADDR_W - 4
- CYC_W, 24, run-cycle counter width

Ports:
- CLK  in  1  single clock
- RESET_N  in  1  asynchronous, active-low reset
- AVL_CS, AVL_READ, AVL_WRITE  in  1 each  Avalon-MM slave controls
- AVL_ADDR  in  ADDR_W  word address
- AVL_BYTE_EN  in  DATA_W/8  byte-lane enables
- AVL_WRITEDATA  in  DATA_W  write data
- AVL_READDATA  out  DATA_W  read data, registered (readLatency = 1)
- HW_RADDR  in  ADDR_W  classifier buffer read address
- HW_RDATA  out  DATA_W  buffer word, registered
- HW_WE  in  1  classifier buffer write strobe
- HW_WADDR  in  ADDR_W  classifier buffer write address
- HW_WDATA  in  DATA_W  classifier buffer write data
- HW_START  out  1  one-cycle run-start pulse
- HW_DONE  in  1  one-cycle run-done pulse
- HW_IS_FACE  in  1  result; valid with HW_DONE
- EXPORT_DATA  out  32  {STATUS[15:0], RESULT[15:0]}, registered, LED conduit

## Operation
Address map, with T = 2**ADDR_W:
- 0..BUF_DEPTH-1: buffer.
- T-4: CTRL. Bit 0 is START (self-clearing, always reads 0). Bit 1 is IRQ_ENABLE (R/W).
- T-3: STATUS. Bit 0 is BUSY (RO). Bit 1 is DONE (W1C). Bit 2 is WR_ERR (W1C).
- T-2: CYCLES (RO).
- T-1: RESULT. Bit 0 is IS_FACE (RO).
- Gap addresses read 0; writes to them are ignored.

Avalon writes:
- Writes honour each byte enable independently, for any pattern, including 0000.
- Buffer writes while BUSY are dropped and set WR_ERR.

HW_WE:
- Writes full words. Addresses at or above BUF_DEPTH are ignored.
- If HW_WE and an Avalon buffer write hit the same address in the same cycle, the HW write wins and the Avalon write is dropped without an error.

State machine:
- States are IDLE, RUN and DONE. Reset state is IDLE.
- IDLE -> RUN: on a CTRL write with byte 0 enabled and START=1. HW_START pulses on the next cycle, CYCLES clears to 0, and BUSY=1.
- RUN: CYCLES increments every cycle and saturates at all-ones. START writes are ignored.
- RUN -> DONE: on HW_DONE. RESULT.IS_FACE <= HW_IS_FACE, DONE=1, BUSY=0.
- DONE -> IDLE: when DONE is cleared via W1C. A START written in DONE is also accepted: it goes to RUN and clears DONE.
- HW_DONE outside RUN is ignored.

Reset values:
- All registers and the buffer are 0, so AVL_READDATA, HW_RDATA and EXPORT_DATA are 0.
- HW_START is 0 and irq (when compiled in) is 0.
- Reset asserted mid-run abandons the run immediately.

## Timing
- Avalon read: AVL_READDATA is valid the cycle after AVL_CS&&AVL_READ. It returns 0 the cycle after a non-read. There is no waitrequest.
- Read-after-write to the same address on consecutive cycles returns the new data.
- Avalon read and write to the same address in the same cycle returns the old data.
- HW_RDATA lags HW_RADDR by 1 cycle. A same-cycle HW/Avalon write to that address is not forwarded; the old data is returned.
- START write in cycle n gives HW_START high in cycle n+1 and BUSY readable from n+1.
- HW_DONE in cycle m gives DONE and RESULT visible to reads issued in cycle m+1.
- CYCLES equals the number of cycles spent in RUN.
- EXPORT_DATA updates 1 cycle after its source registers.

## Configuration
- HAAR_MMIO_IRQ_EN defined: adds output port AVL_IRQ (1 bit, registered). AVL_IRQ = DONE && IRQ_ENABLE. It deasserts the cycle after the DONE W1C.
- Undefined: there is no AVL_IRQ port. CTRL bit 1 is still stored and readable but has no effect.

## Structure
- Package haar_mmio_pkg holds:
  - the state enum (IDLE/RUN/DONE),
  - register offset constants relative to T (CTRL_OFS=4, STATUS_OFS=3, CYCLES_OFS=2, RESULT_OFS=1),
  - bit-index constants for CTRL and STATUS.
- One sub-module, haar_window_buf, holds the BUF_DEPTH x DATA_W store. It has the byte-enabled Avalon write port, the HW write port with priority, and the two registered read ports. The control FSM and registers stay in the top.

## Test plan
- Byte enables: write 0xAABBCCDD to addr 5 with BE=1111, then write 0x11223344 with BE=0101 -> readback one cycle later is 0xAA22CC44.
- Full run: START write; hold HW_DONE low 37 cycles, then pulse HW_DONE with IS_FACE=1 -> HW_START was a single pulse, CYCLES=37, STATUS=0x2, RESULT=1, EXPORT_DATA=0x0002_0001.
- Write protection: during RUN, write to addr 10 -> word unchanged and WR_ERR=1. Write STATUS=0x4 -> WR_ERR=0.
- Collision: Avalon write 0x1 and HW write 0x2 to addr 3 in the same cycle -> addr 3 reads 0x2 and WR_ERR stays 0.
- Boundaries: write to addr BUF_DEPTH and addr T-5 -> both read 0. Read addr T-1 after reset -> 0.
- Interrupt and reset: with HAAR_MMIO_IRQ_EN and IRQ_ENABLE=1, finish a run -> AVL_IRQ=1; W1C DONE -> AVL_IRQ=0 next cycle. Assert RESET_N low during RUN -> state IDLE, all outputs 0.
